// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port data memory: core LSU (port 0) and debug/DMA loader (port 1).
// Grant is combinational in the request cycle; read data returns one cycle after the grant.
module dmem_arbiter #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MAX_LOCK = 4
) (
  input  logic            clk,
  input  logic            rst,

  input  logic            p0_req,
  input  logic            p0_we,
  input  logic [AW-1:0]   p0_addr,
  input  logic [DW-1:0]   p0_wdata,
  input  logic [DW/8-1:0] p0_wmask,
  output logic            p0_gnt,
  output logic            p0_rvalid,
  output logic [DW-1:0]   p0_rdata,

  input  logic            p1_req,
  input  logic            p1_we,
  input  logic [AW-1:0]   p1_addr,
  input  logic [DW-1:0]   p1_wdata,
  input  logic [DW/8-1:0] p1_wmask,
  input  logic            p1_lock,
  output logic            p1_gnt,
  output logic            p1_rvalid,
  output logic [DW-1:0]   p1_rdata,

  output logic            core_stall,

  output logic            mem_en,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_wmask,
  input  logic [DW-1:0]   mem_rdata
);

  localparam logic [3:0] LOCK_MAX = 4'(MAX_LOCK);

  logic       last_gnt;
  logic [3:0] lock_cnt;
  logic       rd_pend;
  logic       rd_owner;
  logic       locked;
  logic       gnt0;
  logic       gnt1;

  // A held lock keeps port 1 granted only until the burst bound is reached.
  assign locked = (lock_cnt != 4'd0) && p1_req && p1_lock && (lock_cnt < LOCK_MAX);

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst) begin
      if (locked) begin
        gnt1 = 1'b1;
      end else if (p0_req && p1_req) begin
        if (last_gnt) gnt0 = 1'b1;
        else          gnt1 = 1'b1;
      end else if (p0_req) begin
        gnt0 = 1'b1;
      end else if (p1_req) begin
        gnt1 = 1'b1;
      end
    end
  end

  assign p0_gnt     = gnt0;
  assign p1_gnt     = gnt1;
  assign core_stall = p0_req & ~gnt0;

  always_comb begin
    mem_en    = gnt0 | gnt1;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wmask = '0;
    if (gnt0) begin
      mem_we    = p0_we;
      mem_addr  = p0_addr;
      mem_wdata = p0_wdata;
      mem_wmask = p0_wmask;
    end else if (gnt1) begin
      mem_we    = p1_we;
      mem_addr  = p1_addr;
      mem_wdata = p1_wdata;
      mem_wmask = p1_wmask;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      last_gnt <= 1'b0;
      lock_cnt <= 4'd0;
      rd_pend  <= 1'b0;
      rd_owner <= 1'b0;
    end else begin
      if (mem_en) last_gnt <= gnt1;
      if (gnt1 && p1_lock) begin
        if (lock_cnt != LOCK_MAX) lock_cnt <= lock_cnt + 4'd1;
      end else if (mem_en) begin
        lock_cnt <= 4'd0;
      end
      rd_pend <= mem_en & ~mem_we;
      if (mem_en && !mem_we) rd_owner <= gnt1;
    end
  end

  // Gating with rst squashes a return that was in flight when reset arrived.
  assign p0_rvalid = rst & rd_pend & ~rd_owner;
  assign p1_rvalid = rst & rd_pend &  rd_owner;
  assign p0_rdata  = p0_rvalid ? mem_rdata : '0;
  assign p1_rdata  = p1_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a byte-masked behavioural memory behind it.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        p0_req, p0_we, p0_gnt, p0_rvalid;
  logic [31:0] p0_addr, p0_wdata, p0_rdata;
  logic [3:0]  p0_wmask;
  logic        p1_req, p1_we, p1_lock, p1_gnt, p1_rvalid;
  logic [31:0] p1_addr, p1_wdata, p1_rdata;
  logic [3:0]  p1_wmask;
  logic        core_stall, mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wmask;

  logic [31:0] mem [0:63];
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.AW(32), .DW(32), .MAX_LOCK(4)) dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_wmask(p0_wmask), .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_wmask(p1_wmask), .p1_lock(p1_lock), .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid),
    .p1_rdata(p1_rdata), .core_stall(core_stall),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_rdata(mem_rdata)
  );

  // Memory: contents preloaded under reset, read data registered one cycle after mem_en.
  always @(posedge clk) begin
    if (!rst) begin
      mem[4]    <= 32'hDEADBEEF;
      mem[8]    <= 32'hAAAAAAAA;
      mem_rdata <= 32'h0;
    end else if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_wmask[b]) mem[mem_addr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= mem[mem_addr[7:2]];
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic nxt;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 32'h10; p0_wdata = '0; p0_wmask = '0;
    p1_req = 1'b0; p1_we = 1'b0; p1_addr = 32'h20; p1_wdata = '0; p1_wmask = '0;
    p1_lock = 1'b0;

    // Held in reset with a pending core request.
    repeat (3) begin
      @(negedge clk);
      chk("rst_p0_gnt", p0_gnt, 0);
      chk("rst_mem_en", mem_en, 0);
      chk("rst_stall", core_stall, 1);
      chk("rst_p0_rvalid", p0_rvalid, 0);
    end

    // Release: core read of 0x10 granted in the same cycle.
    nxt(); rst = 1'b1;
    @(negedge clk);
    chk("rd_p0_gnt", p0_gnt, 1);
    chk("rd_mem_en", mem_en, 1);
    chk("rd_mem_addr", mem_addr, 32'h10);
    chk("rd_mem_we", mem_we, 0);
    chk("rd_stall", core_stall, 0);
    nxt(); p0_req = 1'b0;
    @(negedge clk);
    chk("rd_p0_rvalid", p0_rvalid, 1);
    chk("rd_p0_rdata", p0_rdata, 32'hDEADBEEF);
    chk("rd_p1_rvalid", p1_rvalid, 0);
    chk("rd_p1_rdata", p1_rdata, 0);
    chk("idle_mem_en", mem_en, 0);
    chk("idle_mem_addr", mem_addr, 0);

    // Core halfword write to 0x20, then read back.
    nxt(); p0_req = 1'b1; p0_we = 1'b1; p0_addr = 32'h20; p0_wdata = 32'h12345678; p0_wmask = 4'b0011;
    @(negedge clk);
    chk("wr_p0_gnt", p0_gnt, 1);
    chk("wr_mem_we", mem_we, 1);
    chk("wr_mem_wmask", mem_wmask, 4'b0011);
    chk("wr_mem_wdata", mem_wdata, 32'h12345678);
    nxt(); p0_we = 1'b0; p0_wmask = '0;
    @(negedge clk);
    chk("wr_no_rvalid", p0_rvalid, 0);
    chk("wrb_p0_gnt", p0_gnt, 1);
    nxt(); p0_req = 1'b0;
    @(negedge clk);
    chk("wrb_rvalid", p0_rvalid, 1);
    chk("wrb_rdata", p0_rdata, 32'hAAAA5678);

    // Contention without lock: p1 first, then alternate; rvalid follows each grant.
    p0_addr = 32'h10; p1_addr = 32'h20;
    for (int i = 0; i < 7; i++) begin
      nxt(); p0_req = (i < 6); p1_req = (i < 6);
      @(negedge clk);
      if (i < 6) begin
        chk("cont_p1_gnt", p1_gnt, (i % 2 == 0));
        chk("cont_p0_gnt", p0_gnt, (i % 2 == 1));
      end
      if (i > 0) begin
        chk("cont_p1_rvalid", p1_rvalid, ((i - 1) % 2 == 0));
        chk("cont_p0_rvalid", p0_rvalid, ((i - 1) % 2 == 1));
        chk("cont_rdata", ((i - 1) % 2 == 0) ? p1_rdata : p0_rdata,
            ((i - 1) % 2 == 0) ? 32'hAAAA5678 : 32'hDEADBEEF);
      end
    end

    // Locked burst: 4 grants to p1, core served once, p1 resumes.
    for (int i = 0; i < 6; i++) begin
      nxt(); p0_req = (i < 5); p1_req = 1'b1; p1_lock = 1'b1;
      @(negedge clk);
      chk("lock_p1_gnt", p1_gnt, (i != 4));
      chk("lock_p0_gnt", p0_gnt, (i == 4));
      chk("lock_stall", core_stall, (i < 4));
    end
    nxt(); p0_req = 1'b0; p1_req = 1'b0;

    // Reset arrives right after a locked p1 read grant; its return is squashed.
    nxt(); p1_req = 1'b1; p1_lock = 1'b1;
    @(negedge clk);
    chk("mr_p1_gnt_a", p1_gnt, 1);
    nxt();
    @(negedge clk);
    chk("mr_p1_gnt_t", p1_gnt, 1);
    #1 rst = 1'b0;
    nxt(); rst = 1'b1; p1_req = 1'b0; p1_lock = 1'b0;
    @(negedge clk);
    chk("mr_p1_rvalid", p1_rvalid, 0);
    chk("mr_p1_rdata", p1_rdata, 0);

    // Lock counter and last_gnt cleared: full 4-grant burst before the core.
    for (int i = 0; i < 5; i++) begin
      nxt(); p0_req = 1'b1; p1_req = 1'b1; p1_lock = 1'b1;
      @(negedge clk);
      chk("post_p0_gnt", p0_gnt, (i == 4));
      chk("post_p1_gnt", p1_gnt, (i != 4));
    end
    nxt(); p0_req = 1'b0; p1_req = 1'b0; p1_lock = 1'b0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between two requesters: port 0 = core load/store unit, port 1 = debug/DMA loader.
- Round-robin arbitration with a bounded debug lock for bursts; returns read data one cycle after grant.
- Sits between single_cycle_top's LSU path and the data memory.
- Drives core_stall so the single-cycle core holds its PC while it is waiting for access.

Parameters:
- AW, 32, address width in bits (byte address).
- DW, 32, data width in bits.
- MAX_LOCK, 4, maximum consecutive grants to port 1 while p1_lock is held; 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous active-low reset.
- p0_req  in  1  core access request; held until granted.
- p0_we  in  1  core write enable.
- p0_addr  in  AW  core byte address.
- p0_wdata  in  DW  core write data.
- p0_wmask  in  DW/8  core byte-write mask.
- p0_gnt  out  1  core granted this cycle.
- p0_rvalid  out  1  core read data valid.
- p0_rdata  out  DW  core read data.
- p1_req, p1_we, p1_addr, p1_wdata, p1_wmask: same as the p0 signals, for the debug port.
- p1_lock  in  1  debug requests back-to-back grants.
- p1_gnt, p1_rvalid, p1_rdata  out: same as the p0 outputs, for the debug port.
- core_stall  out  1  equals p0_req & ~p0_gnt.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_wmask  out  DW/8  memory byte mask.
- mem_rdata  in  DW  memory read data, valid the cycle after mem_en with mem_we=0.

Behaviour:
- Reset (rst=0 at posedge):
  - last_gnt <= 0 (port 0 considered last served, so port 1 wins the first contention).
  - lock_cnt <= 0, rd_pend <= 0, rd_owner <= 0.
- While rst=0:
  - p0_gnt = p1_gnt = mem_en = 0.
  - p0_rvalid = p1_rvalid = 0.
  - core_stall = p0_req.
- Grant is combinational in the request cycle T. At most one of p0_gnt/p1_gnt is high.
  - mem_en = p0_gnt | p1_gnt.
  - mem_* fields are muxed from the granted port; they are 0 when nothing is granted.
- Arbitration decision, in priority order:
  1. Locked: if lock_cnt != 0, p1_req & p1_lock, and lock_cnt < MAX_LOCK, grant p1.
  2. Single requester: grant it.
  3. Both requesting: grant the port != last_gnt.
- State updates on each grant at posedge:
  - last_gnt <= granted port.
  - Port 1 granted with p1_lock=1: lock_cnt <= lock_cnt+1, saturating at MAX_LOCK.
  - Otherwise lock_cnt <= 0.
  - When lock_cnt reaches MAX_LOCK and p0_req=1, port 0 is granted next and lock_cnt clears.
  - If p0_req=0 at that point, port 1 keeps being granted through rule 2, and lock_cnt stays at MAX_LOCK until a non-lock grant.
- Read return:
  - A grant with we=0 sets rd_pend <= 1 and rd_owner <= port.
  - In cycle T+1: pX_rvalid = rd_pend & (rd_owner==X), and pX_rdata = mem_rdata.
  - Non-owner rdata is 0.
  - rd_pend clears when the following cycle has no read grant.
  - Back-to-back reads produce rvalid on consecutive cycles in grant order.
- Writes take effect in the grant cycle. A write produces no rvalid.
- Fairness: with both ports requesting continuously and p1_lock=0, grants alternate. Port 0 waits at most MAX_LOCK cycles.
- Request without grant: the requester holds all fields stable; the arbiter samples them only in the grant cycle.
- Reset mid-operation: any pending rvalid is squashed (no rvalid in the cycle after reset is asserted). The lock is cleared.

Test Plan:
- Reset then idle: rst=0 for 3 cycles with p0_req=1 -> p0_gnt=0, mem_en=0, core_stall=1. After rst=1 -> p0_gnt=1 in the same cycle.
- Core read: p0_req=1, p0_we=0, addr=0x10, memory holds 0xDEADBEEF -> mem_en=1 and mem_addr=0x10 in cycle T. p0_rvalid=1 and p0_rdata=0xDEADBEEF in T+1. p1_rvalid=0.
- Core write: p0_we=1, addr=0x20, wdata=0x12345678, wmask=4'b0011 -> mem_we=1 with mem_wmask=4'b0011. No rvalid. A read of 0x20 then returns the low halfword updated.
- Contention: both ports request reads for 6 cycles, lock=0 -> grant sequence p1,p0,p1,p0,p1,p0. Each rvalid appears one cycle after its port's grant.
- Lock bound: MAX_LOCK=4, p1_req=p1_lock=1, p0_req=1 from cycle 0 (first grant goes to p1) -> p1 granted for exactly 4 cycles, then p0 granted once, then p1 resumes. core_stall=1 for exactly 4 cycles.
- Reset mid-read: p1 read granted in cycle T, rst=0 at the T posedge -> p1_rvalid=0 in T+1. lock_cnt=0 and last_gnt=0 after reset is released.
